// File: rtl/pixel_line_buffer.sv
// pixel_line_buffer: ping-pong scanline buffer; one bank is cleared then filled while the other is read out.
// A line_start swaps banks, restarts the clear of the new fill bank and rewinds the read pointer.
module pixel_line_buffer #(
  parameter int H_ACTIVE = 640,
  parameter int X_W = 10
) (
  input  logic           clk_pix,
  input  logic           rst_n,
  input  logic           line_start,
  input  logic           de_in,
  input  logic           wr_valid,
  output logic           wr_ready,
  input  logic [X_W-1:0] wr_x,
  input  logic [8:0]     wr_colour,
  output logic [8:0]     colour_pix,
  output logic           de_out,
  output logic           underrun
);
  localparam int AW = $clog2(2 * H_ACTIVE);
  localparam logic [X_W:0] H_W = (X_W + 1)'(H_ACTIVE);
  localparam logic [X_W-1:0] LAST = X_W'(H_ACTIVE - 1);
  typedef enum logic {CLEAR, FILL} state_t;
  state_t state_q, state_d;
  logic bank_q, primed_q, valid_q, de_q, underrun_q;
  logic [X_W-1:0] clr_cnt_q, clr_cnt_d, wa;
  logic [X_W:0] rd_ptr_q, rd_ptr_d, rd_addr;
  logic [AW-1:0] w_idx, r_idx;
  logic [8:0] mem [0:2*H_ACTIVE-1];
  logic [8:0] rd_data_q, wd;
  logic we;
  assign wr_ready = (state_q == FILL) && !line_start;
  assign rd_addr = line_start ? '0 : rd_ptr_q;
  // bank_q selects the fill bank; the display bank is the other one
  always_comb begin
    we = !line_start && (state_q == CLEAR || (wr_valid && {1'b0, wr_x} < H_W));
    wa = (state_q == CLEAR) ? clr_cnt_q : wr_x;
    wd = (state_q == CLEAR) ? 9'd0 : wr_colour;
    w_idx = bank_q ? AW'(H_ACTIVE) + AW'(wa) : AW'(wa);
    r_idx = bank_q ? AW'(rd_addr) : AW'(H_ACTIVE) + AW'(rd_addr);
    state_d = line_start ? CLEAR : (state_q == CLEAR && clr_cnt_q == LAST) ? FILL : state_q;
    clr_cnt_d = line_start ? '0 : (state_q == CLEAR) ? clr_cnt_q + 1'b1 : clr_cnt_q;
    rd_ptr_d = line_start ? '0 : (de_in && rd_ptr_q != H_W) ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end
  // storage is not reset so it can map onto block RAM; valid_q gates stale data
  always_ff @(posedge clk_pix) begin
    if (we) mem[w_idx] <= wd;
    rd_data_q <= mem[r_idx];
  end
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      bank_q <= 1'b0;
      clr_cnt_q <= '0;
      rd_ptr_q <= '0;
      primed_q <= 1'b0;
      valid_q <= 1'b0;
      de_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_q ^ line_start;
      clr_cnt_q <= clr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      primed_q <= primed_q | (line_start && state_q == FILL);
      valid_q <= de_in && primed_q && rd_addr < H_W;
      de_q <= de_in;
      underrun_q <= line_start && state_q == CLEAR;
    end
  end
  assign colour_pix = valid_q ? rd_data_q : 9'd0;
  assign de_out = de_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_pixel_line_buffer.sv
// tb_pixel_line_buffer: directed checks of clear timing, bank swap, underrun, write stalls and reset abort.
module tb_pixel_line_buffer;
  logic clk = 1'b0, rst_n = 1'b0, line_start = 1'b0, de_in = 1'b0, wr_valid = 1'b0;
  logic [9:0] wr_x = '0;
  logic [8:0] wr_colour = '0;
  logic wr_ready, de_out, underrun;
  logic [8:0] colour_pix;
  int checks = 0, errors = 0;
  int n, nz, nr, zero0;

  pixel_line_buffer #(.H_ACTIVE(640), .X_W(10)) dut (
    .clk_pix(clk), .rst_n(rst_n), .line_start(line_start), .de_in(de_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_colour(wr_colour),
    .colour_pix(colour_pix), .de_out(de_out), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic count_not_ready(output int cnt, output int nonzero);
    cnt = 0;
    nonzero = 0;
    while (!wr_ready && cnt < 2000) begin
      cnt++;
      if (colour_pix !== 9'd0) nonzero++;
      @(negedge clk);
    end
  endtask

  task automatic write_px(input logic [9:0] x, input logic [8:0] c, input string tag);
    wr_valid = 1'b1;
    wr_x = x;
    wr_colour = c;
    #1;
    chk(tag, wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_ls();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic read_line(input int len, input int p1, input logic [8:0] v1, input int p2,
                           input logic [8:0] v2, input string tag, output int not_ready);
    int bad;
    logic [8:0] want, c1, c2;
    bad = 0;
    not_ready = 0;
    c1 = 'x;
    c2 = 'x;
    for (int i = 1; i <= len; i++) begin
      de_in = 1'b1;
      @(negedge clk);
      want = (i == p1) ? v1 : (i == p2) ? v2 : 9'd0;
      if (i == p1) c1 = colour_pix;
      if (i == p2) c2 = colour_pix;
      if (colour_pix !== want || de_out !== 1'b1 || underrun !== 1'b0) bad++;
      if (!wr_ready) not_ready++;
    end
    de_in = 1'b0;
    @(negedge clk);
    chk({tag, "_p1"}, c1, v1);
    if (p2 <= len) chk({tag, "_p2"}, c2, v2);
    chk({tag, "_bad_samples"}, bad, 0);
    chk({tag, "_de_out_fall"}, de_out, 0);
    chk({tag, "_colour_idle"}, colour_pix, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_colour", colour_pix, 0);
    chk("rst_de_out", de_out, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_wr_ready", wr_ready, 0);
    de_in = 1'b1;
    rst_n = 1'b1;
    #1;
    count_not_ready(n, nz);
    chk("init_clear_cycles", n, 640);
    chk("init_colour_unprimed", nz, 0);
    de_in = 1'b0;
    write_px(10'd0, 9'h1A5, "wr_x0");
    write_px(10'd639, 9'h003, "wr_x639");
    write_px(10'd700, 9'h1FF, "wr_oor_accept");
    pulse_ls();
    chk("ls1_no_underrun", underrun, 0);
    read_line(700, 1, 9'h1A5, 640, 9'h003, "line1", nr);
    write_px(10'd5, 9'h0AA, "wr_x5");
    pulse_ls();
    chk("lsA_no_underrun", underrun, 0);
    read_line(10, 6, 9'h0AA, 1, 9'h000, "lineA", nr);
    repeat (88) @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    chk("underrun_pulse", underrun, 1);
    zero0 = wr_ready ? 0 : 1;
    line_start = 1'b0;
    read_line(640, 1, 9'h000, 640, 9'h003, "lineB", nr);
    chk("underrun_clear_cycles", zero0 + nr, 640);
    chk("lineB_ready_after", wr_ready, 1);
    write_px(10'd5, 9'h0AA, "wr_x5b");
    wr_valid = 1'b1;
    wr_x = 10'd10;
    wr_colour = 9'h155;
    line_start = 1'b1;
    #1;
    chk("ready_low_on_ls", wr_ready, 0);
    @(negedge clk);
    line_start = 1'b0;
    read_line(20, 6, 9'h0AA, 11, 9'h000, "lineD", nr);
    chk("lineD_held_not_ready", nr, 20);
    count_not_ready(n, nz);
    chk("held_write_accepted", wr_ready, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    pulse_ls();
    read_line(12, 11, 9'h155, 1, 9'h000, "lineC", nr);
    de_in = 1'b1;
    @(negedge clk);
    chk("pre_reset_de_out", de_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_de_out", de_out, 0);
    chk("async_rst_wr_ready", wr_ready, 0);
    chk("async_rst_colour", colour_pix, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    count_not_ready(n, nz);
    chk("rerst_clear_cycles", n, 640);
    chk("rerst_colour_unprimed", nz, 0);
    de_in = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
